// File: rtl/debug_slave_sysclk_mc.sv
// rtl/debug_slave_sysclk_mc.sv - system-clock half of the debug slave: strobe sync, jdo capture, command decode
// Optional acknowledge handshake (HOLD state) is built when DBG_ACTION_ACK_EN is defined.
module debug_slave_sysclk_mc #(
   parameter int IR_W        = 2,
   parameter int SR_W        = 38,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16,
   localparam int NUM_CMD    = 2**IR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [IR_W-1:0]    ir_in,
   input  logic [SR_W-1:0]    sr,
   input  logic               vs_uir,
   input  logic               vs_udr,
   input  logic               action_ack,
   input  logic               clr_overrun,
   output logic [SR_W-1:0]    jdo,
   output logic [IR_W-1:0]    ir_q,
   output logic [NUM_CMD-1:0] take_action,
   output logic [NUM_CMD-1:0] take_no_action,
   output logic               busy,
   output logic               overrun,
   output logic [CNT_W-1:0]   cmd_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1
`ifdef DBG_ACTION_ACK_EN
      , HOLD = 2'd2
`endif
   } state_t;

   state_t state, state_n;

   logic [SYNC_STAGES-1:0] uir_sync, udr_sync;
   logic                   uir_dly, udr_dly;
   logic                   uir_p, udr_p;
   logic                   capture, strobe_clr, ovr_evt;
   logic [NUM_CMD-1:0]     cmd_sel;

`ifndef DBG_ACTION_ACK_EN
   logic unused_action_ack;
   assign unused_action_ack = action_ack;
`endif

   // Each strobe: SYNC_STAGES metastability flops, then one delay flop for edge detect.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uir_sync <= '0;
         udr_sync <= '0;
         uir_dly  <= 1'b0;
         udr_dly  <= 1'b0;
      end else begin
         uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
         udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
         uir_dly  <= uir_sync[SYNC_STAGES-1];
         udr_dly  <= udr_sync[SYNC_STAGES-1];
      end
   end

   assign uir_p   = uir_sync[SYNC_STAGES-1] & ~uir_dly;
   assign udr_p   = udr_sync[SYNC_STAGES-1] & ~udr_dly;
   assign cmd_sel = NUM_CMD'(1) << ir_q;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n    = state;
      capture    = 1'b0;
      strobe_clr = 1'b0;
      ovr_evt    = 1'b0;
      case (state)
         IDLE: begin
            if (udr_p) begin
               capture = 1'b1;
               state_n = EXEC;
            end
         end
         EXEC: begin
            ovr_evt = udr_p;
`ifdef DBG_ACTION_ACK_EN
            if (action_ack) begin
               strobe_clr = 1'b1;
               state_n    = IDLE;
            end else begin
               state_n    = HOLD;
            end
`else
            strobe_clr = 1'b1;
            state_n    = IDLE;
`endif
         end
`ifdef DBG_ACTION_ACK_EN
         HOLD: begin
            ovr_evt = udr_p;
            if (action_ack) begin
               strobe_clr = 1'b1;
               state_n    = IDLE;
            end
         end
`endif
         default: begin
            strobe_clr = 1'b1;
            state_n    = IDLE;
         end
      endcase
   end

   // Decode uses the pre-update ir_q when UIR and UDR land in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir_q           <= '0;
         jdo            <= '0;
         take_action    <= '0;
         take_no_action <= '0;
         overrun        <= 1'b0;
         cmd_count      <= '0;
      end else begin
         if (uir_p) ir_q <= ir_in;
         if (capture) begin
            jdo            <= sr;
            take_action    <= sr[SR_W-1] ? cmd_sel : '0;
            take_no_action <= sr[SR_W-1] ? '0 : cmd_sel;
            cmd_count      <= cmd_count + CNT_W'(1);
         end else if (strobe_clr) begin
            take_action    <= '0;
            take_no_action <= '0;
         end
         if (ovr_evt)          overrun <= 1'b1;
         else if (clr_overrun) overrun <= 1'b0;
      end
   end

endmodule
